// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: each channel delayed by a programmable number of accepted strobes, then summed.
// Latency 1 cycle from in_valid to out_valid; no backpressure, every strobe is accepted.
module delay_sum_beamformer #(
   parameter int  N_CH      = 4,
   parameter int  SAMPLE_W  = 8,
   parameter int  MAX_DELAY = 7,
   parameter int  DELAY_W   = $clog2(MAX_DELAY + 1),
   localparam int OUT_W     = SAMPLE_W + $clog2(N_CH),
   localparam int CH_W      = $clog2(N_CH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [N_CH*SAMPLE_W-1:0] in_data,
   input  logic                     avg,
   input  logic                     cfg_we,
   input  logic [CH_W-1:0]          cfg_ch,
   input  logic [DELAY_W-1:0]       cfg_delay,
   output logic                     out_valid,
   output logic [OUT_W-1:0]         out_data
);
   localparam int LOG_N = $clog2(N_CH);

   logic signed [SAMPLE_W-1:0] r_hist [N_CH][MAX_DELAY];
   logic        [DELAY_W-1:0]  r_delay [N_CH];
   logic                       r_out_valid;
   logic signed [OUT_W-1:0]    r_out_data;

   logic signed [SAMPLE_W-1:0] w_samp [N_CH];
   logic signed [SAMPLE_W-1:0] w_tap [N_CH];
   logic signed [OUT_W-1:0]    w_sum;
   logic signed [OUT_W-1:0]    w_mean;
   logic        [DELAY_W-1:0]  w_cfg_delay;

   // Tap mux is a compare chain rather than an index so the delay width never has to match the history depth.
   always_comb begin
      w_sum = '0;
      for (int c = 0; c < N_CH; c++) begin
         w_samp[c] = in_data[c*SAMPLE_W +: SAMPLE_W];
         w_tap[c]  = w_samp[c];
         for (int t = 0; t < MAX_DELAY; t++) begin
            if (r_delay[c] == DELAY_W'(t + 1)) begin
               w_tap[c] = r_hist[c][t];
            end
         end
         w_sum = w_sum + OUT_W'(w_tap[c]);
      end
   end

   assign w_mean      = w_sum >>> LOG_N;
   assign w_cfg_delay = (cfg_delay > DELAY_W'(MAX_DELAY)) ? DELAY_W'(MAX_DELAY) : cfg_delay;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         for (int c = 0; c < N_CH; c++) begin
            r_delay[c] <= '0;
            for (int t = 0; t < MAX_DELAY; t++) begin
               r_hist[c][t] <= '0;
            end
         end
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_out_data <= avg ? w_mean : w_sum;
            for (int c = 0; c < N_CH; c++) begin
               for (int t = MAX_DELAY - 1; t > 0; t--) begin
                  r_hist[c][t] <= r_hist[c][t-1];
               end
               r_hist[c][0] <= w_samp[c];
            end
         end
         // Out-of-range channel indices match no loop iteration, so such writes fall away.
         for (int c = 0; c < N_CH; c++) begin
            if (cfg_we && (cfg_ch == CH_W'(c))) begin
               r_delay[c] <= w_cfg_delay;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Bench for delay_sum_beamformer: strobe-history model checked every cycle plus hand-computed literals.
module tb_delay_sum_beamformer;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        avg;
   logic        cfg_we;
   logic [2:0]  cfg_ch;
   logic [3:0]  cfg_delay;
   logic        out_valid;
   logic [9:0]  out_data;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // Model state: per-channel list of accepted samples, most recent first.
   int m_hist [4][7];
   int m_dly [4];
   int exp_data;
   bit exp_valid;
   int m_sum;
   int m_s;

   delay_sum_beamformer #(
      .N_CH(4), .SAMPLE_W(8), .MAX_DELAY(7), .DELAY_W(4)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .avg(avg),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
      .out_valid(out_valid), .out_data(out_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) begin
         exp_valid = 0;
         exp_data  = 0;
         for (int c = 0; c < 4; c++) begin
            m_dly[c] = 0;
            for (int t = 0; t < 7; t++) m_hist[c][t] = 0;
         end
      end else begin
         exp_valid = in_valid;
         if (in_valid) begin
            m_sum = 0;
            for (int c = 0; c < 4; c++) begin
               m_s = $signed(in_data[c*8 +: 8]);
               m_sum += (m_dly[c] == 0) ? m_s : m_hist[c][m_dly[c]-1];
            end
            exp_data = avg ? (m_sum - (((m_sum % 4) + 4) % 4)) / 4 : m_sum;
            for (int c = 0; c < 4; c++) begin
               for (int t = 6; t > 0; t--) m_hist[c][t] = m_hist[c][t-1];
               m_hist[c][0] = $signed(in_data[c*8 +: 8]);
            end
         end
         if (cfg_we && cfg_ch < 4) m_dly[cfg_ch] = (cfg_delay > 7) ? 7 : int'(cfg_delay);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (out_valid !== exp_valid) begin
            errors++;
            $display("FAIL model_valid t=%0t: got %0b want %0b", $time, out_valid, exp_valid);
         end
         checks++;
         if ($isunknown(out_data) || int'($signed(out_data)) != exp_data) begin
            errors++;
            $display("FAIL model_data t=%0t: got %0d want %0d", $time, $signed(out_data), exp_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   task automatic step(input bit v, input int s0, input int s1, input int s2, input int s3,
                       input bit a, input bit we, input int ch, input int d);
      in_valid  = v;
      in_data   = {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
      avg       = a;
      cfg_we    = we;
      cfg_ch    = 3'(ch);
      cfg_delay = 4'(d);
      tick();
      in_valid  = 0;
      cfg_we    = 0;
   endtask

   task automatic strobe(input int s0, input int s1, input int s2, input int s3, input bit a);
      step(1, s0, s1, s2, s3, a, 0, 0, 0);
   endtask

   task automatic cfg(input int ch, input int d);
      step(0, 0, 0, 0, 0, 0, 1, ch, d);
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      rst = 0;
   endtask

   int seq [5] = '{1, 1, 1, 1, 0};

   initial begin
      rst = 1; in_valid = 0; in_data = '0; avg = 0; cfg_we = 0; cfg_ch = '0; cfg_delay = '0;
      tick(); tick();
      rst = 0;
      chk_en = 1;

      // 1: reset state and single strobe
      lit("reset_valid", int'(out_valid), 0);
      lit("reset_data", int'($signed(out_data)), 0);
      strobe(10, 20, 30, 40, 0);
      lit("t1_valid", int'(out_valid), 1);
      lit("t1_sum", int'($signed(out_data)), 100);
      tick();
      lit("t1_valid_drop", int'(out_valid), 0);
      lit("t1_hold", int'($signed(out_data)), 100);

      // 2: staggered delays spread an impulse, idle cycles do not age history
      do_reset();
      cfg(0, 0); cfg(1, 1); cfg(2, 2); cfg(3, 3);
      for (int i = 0; i < 5; i++) begin
         if (i == 0) strobe(1, 1, 1, 1, 0); else strobe(0, 0, 0, 0, 0);
         lit($sformatf("t2_seq%0d", i), int'($signed(out_data)), seq[i]);
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 0) strobe(1, 1, 1, 1, 0); else strobe(0, 0, 0, 0, 0);
         lit($sformatf("t2_idle_seq%0d", i), int'($signed(out_data)), seq[i]);
         tick(); tick();
      end

      // 3: negative extremes and floor averaging
      do_reset();
      strobe(-128, -128, -128, -128, 0);
      lit("t3_min_sum", int'($signed(out_data)), -512);
      lit("t3_min_raw", int'(out_data), 'h200);
      strobe(-128, -128, -128, -128, 1);
      lit("t3_min_avg", int'($signed(out_data)), -128);
      strobe(-1, 0, 0, 0, 1);
      lit("t3_floor", int'($signed(out_data)), -1);
      strobe(3, 2, 1, 1, 1);
      lit("t3_avg_pos", int'($signed(out_data)), 1);

      // 4: clamped delay write and ignored out-of-range channel
      do_reset();
      cfg(2, 9);
      for (int i = 1; i <= 8; i++) begin
         if (i == 1) strobe(0, 0, 1, 0, 0); else strobe(0, 0, 0, 0, 0);
         lit($sformatf("t4_clamp_out%0d", i), int'($signed(out_data)), (i == 8) ? 1 : 0);
      end
      cfg(5, 3);
      strobe(1, 1, 1, 1, 0);
      lit("t4_ignored_first", int'($signed(out_data)), 3);
      for (int i = 2; i <= 8; i++) strobe(0, 0, 0, 0, 0);
      lit("t4_ignored_eighth", int'($signed(out_data)), 1);

      // 5: delay write coincident with a strobe takes effect on the next one
      do_reset();
      strobe(1, 0, 0, 0, 0);
      lit("t5_out1", int'($signed(out_data)), 1);
      step(1, 2, 0, 0, 0, 0, 1, 0, 2);
      lit("t5_out2", int'($signed(out_data)), 2);
      strobe(3, 0, 0, 0, 0);
      lit("t5_out3", int'($signed(out_data)), 1);
      strobe(4, 0, 0, 0, 0);
      lit("t5_out4", int'($signed(out_data)), 2);

      // 6: reset mid-stream overrides a strobe and discards history and delays
      do_reset();
      cfg(0, 3); cfg(1, 3); cfg(2, 3); cfg(3, 3);
      for (int i = 1; i <= 5; i++) strobe(i, i, i, i, 0);
      lit("t6_pre_reset", int'($signed(out_data)), 8);
      rst = 1;
      step(1, 9, 9, 9, 9, 0, 1, 0, 5);
      rst = 0;
      lit("t6_valid_after_rst", int'(out_valid), 0);
      lit("t6_data_after_rst", int'($signed(out_data)), 0);
      strobe(5, 6, 7, 8, 0);
      lit("t6_first_sum", int'($signed(out_data)), 26);
      cfg(0, 2); cfg(1, 3); cfg(2, 4); cfg(3, 5);
      strobe(0, 0, 0, 0, 0);
      lit("t6_history_cleared", int'($signed(out_data)), 0);
      tick();

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/delay_sum_beamformer.md
# delay_sum_beamformer

Parametrised delay-and-sum beamformer core, the generalised successor to the fixed beamformer used in the `tt_um_beamformer` top. It accepts one signed sample per channel per input strobe and delays each channel by a runtime-programmable number of sample periods. It then sums the aligned samples into a single registered output. It sits between the pad-level input demux and the output formatter, and a delay-config write port is exposed for steering.

## Interface

Parameters:
- `N_CH`, 4: number of channels; power of two, ≥2.
- `SAMPLE_W`, 8: signed two's-complement sample width per channel.
- `MAX_DELAY`, 7: largest programmable delay, in samples; ≥1.
- `DELAY_W`, $clog2(`MAX_DELAY`+1): width of a delay value.
- `OUT_W`, `SAMPLE_W`+$clog2(`N_CH`): output width; derived, not overridden.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: sample strobe; one sample set accepted per cycle it is high.
- `in_data` in `N_CH`*`SAMPLE_W`: packed samples, channel 0 in the LSBs.
- `avg` in 1: 0 = output sum; 1 = output mean (sum arithmetic-shifted right by $clog2(`N_CH`)).
- `cfg_we` in 1: delay write strobe.
- `cfg_ch` in $clog2(`N_CH`)+1: channel index to write.
- `cfg_delay` in `DELAY_W`: delay value to write.
- `out_valid` out 1: one-cycle pulse, output updated.
- `out_data` out `OUT_W`: signed beam sample.

## Operation

- Per channel: shift register of `MAX_DELAY` signed entries, plus a `DELAY_W` delay register.
- On a cycle with `in_valid`=1, each channel selects a tap by its delay `d`.
  - `d`=0 selects the current `in_data` sample.
  - `d`≥1 selects the sample accepted `d` strobes earlier, i.e. shift-register entry `d`-1.
  - All shift registers then shift in the current sample.
- Delays count accepted strobes, not clock cycles. Idle cycles do not age history.
- Arithmetic:
  - Each selected tap is sign-extended to `OUT_W` and all `N_CH` taps are summed. No overflow is possible at `OUT_W`.
  - With `avg`=1, the result is the arithmetic right shift of the sum, sign-extended back to `OUT_W`. This is truncation toward −∞.
  - `avg` is sampled on the same edge as `in_valid`.
- Config writes:
  - When `cfg_we`=1 and `cfg_ch`<`N_CH`, the delay register of channel `cfg_ch` is loaded.
  - If `cfg_delay`>`MAX_DELAY`, the stored value is clamped to `MAX_DELAY`.
  - If `cfg_ch`≥`N_CH`, the write is ignored and no state changes.
- `cfg_we` and `in_valid` in the same cycle: the sample uses the old delay; the new delay applies from the next strobe.
- History is not cleared on a delay change. After a change, the output reflects retained history immediately.
- No backpressure. Input is always accepted.

## Timing

- Reset (`rst`=1 at an edge) sets:
  - all shift-register entries to 0;
  - all delays to 0;
  - `out_data` to 0 and `out_valid` to 0.
  
  Reset overrides a simultaneous `in_valid` or `cfg_we`. Both are discarded.
- Reset mid-stream discards all history. The first post-reset strobe sees zero history.
- Latency: `in_valid` high at edge k gives `out_valid`=1 and the new `out_data` after edge k+1, i.e. 1 cycle.
- `out_valid` is high for exactly one cycle per accepted strobe. With back-to-back strobes it stays high continuously.
- `out_data` holds its last value while no strobe is accepted.
- Maximum throughput is one sample set per clock.

## Test plan

Defaults for all scenarios: `N_CH`=4, `SAMPLE_W`=8, `MAX_DELAY`=7.

1. Reset, then a single strobe with ch0..3 = 10, 20, 30, 40 and `avg`=0 → one cycle later `out_valid`=1 and `out_data`=100; the next cycle `out_valid`=0 and `out_data` holds 100.
2. Program delays ch0..3 = 0, 1, 2, 3. Strobe an impulse of 1 on all channels, then 4 strobes of zeros → `out_data` sequence 1, 1, 1, 1, 0. Repeat with idle cycles between strobes → identical sequence.
3. All channels = −128:
   - `avg`=0 → `out_data`=−512 (10'h200).
   - `avg`=1 → −128.
   - Channels = −1, 0, 0, 0 with `avg`=1 → −1 (floor).
4. `cfg_delay`=9 written to ch2 → stored delay 7; verify with an impulse on ch2 only, which appears on the 8th output. `cfg_ch`=5 written with delay 3 → no channel changes.
5. Delays all 0. Stream 1, 2, 3, 4 on ch0 (other channels 0) while writing ch0 delay=2 in the same cycle as sample 2 → outputs 1, 2, 1, 2.
6. Stream ramp 1..5 with delays 3, then assert `rst` for one cycle together with `in_valid`:
   - `out_valid` stays 0 in the cycle after reset.
   - All delays read back as 0.
   - The next strobe's output equals that strobe's channel sum.
